// File: rtl/vector_mac_reader.sv
// Dot-product read stage: streams VECTOR_WIDTH operand pairs from sync-read A/B
// memories, multiply-accumulates them and hands the sum downstream over valid/ready.
module vector_mac_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int ADDR_WIDTH   = 5,
  parameter int RESULT_WIDTH = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   mem_a_data,
  input  logic [DATA_WIDTH-1:0]   mem_b_data,
  output logic [RESULT_WIDTH-1:0] result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy,
  output logic                    reading_done
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, HOLD} state_t;

  localparam int CW = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(VECTOR_WIDTH - 1);

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt;
  logic                    rd_vld;
  logic [RESULT_WIDTH-1:0] acc, acc_nx;
  logic [2*DATA_WIDTH-1:0] prod;

  assign prod   = mem_a_data * mem_b_data;
  // rd_vld marks the cycle where memory data from the previous read is present
  assign acc_nx = rd_vld ? acc + RESULT_WIDTH'(prod) : acc;

  assign mem_rd_en    = (state == READ);
  assign busy         = (state != IDLE);
  assign reading_done = (state == FLUSH);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    if (cnt == LAST) state_nx = FLUSH;
      FLUSH:   state_nx = HOLD;
      HOLD:    if (result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_vld       <= 1'b0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      mem_rd_addr  <= '0;
    end else begin
      state  <= state_nx;
      rd_vld <= mem_rd_en;
      acc    <= acc_nx;
      case (state)
        IDLE: if (start) begin
          mem_rd_addr <= base_addr;
          cnt         <= '0;
          acc         <= '0;
        end
        READ: begin
          cnt <= cnt + 1'b1;
          // stop advancing on the last read so the address holds its final value
          if (cnt != LAST) mem_rd_addr <= mem_rd_addr + 1'b1;
        end
        FLUSH: begin
          result       <= acc_nx;
          result_valid <= 1'b1;
        end
        HOLD: if (result_ready) result_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
